// File: rtl/serializador_tx_if.sv
// ---------------------------------------------------------------------------
// serializador_tx_if
// Byte-in / bit-out bundle of the transmit serializer.
//   data_in     [7:0] byte offered to the serializer FIFO
//   valid_in          data_in holds a byte to queue
//   ready_out         serializer FIFO can take a byte this cycle
//   data_out          serial bit stream, MSB first
//   byte_strobe       marks the first bit of every byte on data_out
//   comma_out         current byte on data_out is an inserted comma/idle symbol
//   sync_done         initial comma burst has been launched
// master: the byte producer (testbench / upstream logic)
// slave : the serializer itself
// ---------------------------------------------------------------------------
interface serializador_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       byte_strobe;
  logic       comma_out;
  logic       sync_done;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  byte_strobe,
    input  comma_out,
    input  sync_done
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output byte_strobe,
    output comma_out,
    output sync_done
  );
endinterface

// File: rtl/serializador_tx.sv
// ---------------------------------------------------------------------------
// serializador_tx
// Parallel-to-serial transmit stage feeding the PHY RX lane. Bytes are queued
// in a small FIFO behind a valid/ready handshake and shifted out MSB first,
// one bit per clk_32f. After reset N_SYNC comma symbols are forced so the
// receiver can lock; afterwards the comma doubles as the idle filler.
//   clk_32f   bit clock, all state updates on its rising edge
//   reset     asynchronous, active-low; clears every register immediately
//   bus       serializador_tx_if.slave (data_in/valid_in/ready_out,
//             data_out/byte_strobe/comma_out/sync_done)
// ---------------------------------------------------------------------------
module serializador_tx #(
  parameter int         DEPTH    = 4,
  parameter int         N_SYNC   = 4,
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input  logic               clk_32f,
  input  logic               reset,
  serializador_tx_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(N_SYNC + 1);

  typedef enum logic {
    ST_SYNC,
    ST_RUN
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_bitCnt;
  logic [SW-1:0]   r_syncCnt;
  logic [6:0]      r_shreg;
  logic            r_dataOut;
  logic            r_byteStrobe;
  logic            r_commaOut;
  logic            r_syncDone;

  logic            w_load;
  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_byte;

  // A load edge starts a new byte. The FIFO is only popped on load edges in
  // RUN, and only from registered contents, so a byte written on the same
  // edge can never be sent in that slot. ready_out is gated by reset so it
  // drops the instant reset is asserted.
  assign w_load  = (r_bitCnt == 3'd0);
  assign w_ready = reset && (r_count != CW'(DEPTH));
  assign w_push  = bus.valid_in && w_ready;
  assign w_pop   = w_load && (r_state == ST_RUN) && (r_count != '0);
  assign w_byte  = w_pop ? r_mem[r_rdPtr] : IDLE_SYM;

  assign bus.ready_out   = w_ready;
  assign bus.data_out    = r_dataOut;
  assign bus.byte_strobe = r_byteStrobe;
  assign bus.comma_out   = r_commaOut;
  assign bus.sync_done   = r_syncDone;

  // FIFO storage needs no reset: flushing the pointers and count is what
  // makes stale entries unreachable.
  always_ff @(posedge clk_32f) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.data_in;
    end
  end

  // Pointer/count bookkeeping, bit timing and the SYNC/RUN state machine.
  // Pointers are AW bits wide so they wrap modulo the power-of-two depth.
  // On a load edge the chosen byte's MSB goes straight to data_out and the
  // remaining seven bits are parked in the shift register; the other seven
  // edges walk that register out. The comma count finishes on the load edge
  // that launches the last sync comma, which is also where RUN begins.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_SYNC;
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_bitCnt     <= 3'd0;
      r_syncCnt    <= '0;
      r_shreg      <= 7'd0;
      r_dataOut    <= 1'b0;
      r_byteStrobe <= 1'b0;
      r_commaOut   <= 1'b0;
      r_syncDone   <= 1'b0;
    end else begin
      r_bitCnt <= r_bitCnt + 3'd1;

      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end

      if (w_load) begin
        r_dataOut    <= w_byte[7];
        r_shreg      <= w_byte[6:0];
        r_byteStrobe <= 1'b1;
        if (r_state == ST_SYNC) begin
          r_commaOut <= 1'b1;
          r_syncCnt  <= r_syncCnt + SW'(1);
          if (r_syncCnt == SW'(N_SYNC - 1)) begin
            r_state    <= ST_RUN;
            r_syncDone <= 1'b1;
          end
        end else begin
          r_commaOut <= ~w_pop;
        end
      end else begin
        r_dataOut    <= r_shreg[6];
        r_shreg      <= {r_shreg[5:0], 1'b0};
        r_byteStrobe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serializador_tx.sv
// ---------------------------------------------------------------------------
// tb_serializador_tx
// Directed bench for serializador_tx. Posedges are numbered from 1 counting
// from reset release; outputs are sampled on the following negedge. Each
// cycle's observation is the vector {data_out, byte_strobe, comma_out,
// sync_done} set against a hand-derived expectation.
// ---------------------------------------------------------------------------
module tb_serializador_tx;

  logic clk_32f;
  logic reset;
  int   errors;
  int   checks;

  serializador_tx_if bus ();

  serializador_tx #(
    .DEPTH   (4),
    .N_SYNC  (4),
    .IDLE_SYM(8'hBC)
  ) dut (
    .clk_32f(clk_32f),
    .reset  (reset),
    .bus    (bus)
  );

  // Free-running bit clock, rising edges at 5, 15, 25 ...
  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  // Advance one bit time and land on the sampling (falling) edge.
  task automatic step();
    @(posedge clk_32f);
    @(negedge clk_32f);
  endtask

  // Hold reset low for two posedges, then release on a falling edge so the
  // next rising edge is posedge 1.
  task automatic applyStimulus_reset();
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  // Everything is cleared while reset is low.
  task automatic test_reset();
    logic [4:0] obs;
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    @(negedge clk_32f);
    @(negedge clk_32f);
    obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done, bus.ready_out};
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b expected 00000", obs);
    end
    reset = 1'b1;
  endtask

  // T1: no pushes, commas throughout, sync_done after posedge 25.
  task automatic test_sync_idle();
    logic [7:0] expByte;
    logic [3:0] obs;
    logic [3:0] exp;
    expByte = 8'hBC;
    for (int p = 1; p <= 32; p++) begin
      step();
      exp = {expByte[7 - ((p - 1) % 8)], ((p - 1) % 8) == 0, 1'b1, p >= 25};
      obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL sync_idle p=%0d: got %b expected %b", p, obs, exp);
      end
    end
  endtask

  // T2: A5 pushed on posedge 3 waits behind the four sync commas.
  task automatic test_push_in_sync();
    logic [7:0] slots [6];
    logic [7:0] expByte;
    logic [3:0] obs;
    logic [3:0] exp;
    int         s;
    slots = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'hBC};
    applyStimulus_reset();
    for (int p = 1; p <= 48; p++) begin
      if (p == 3) begin
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hA5;
      end else begin
        bus.valid_in = 1'b0;
      end
      step();
      s       = (p - 1) / 8;
      expByte = slots[s];
      exp = {expByte[7 - ((p - 1) % 8)], ((p - 1) % 8) == 0, s != 4, p >= 25};
      obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL push_in_sync p=%0d: got %b expected %b", p, obs, exp);
      end
    end
    bus.valid_in = 1'b0;
  endtask

  // T3: five back-to-back bytes into a four-deep FIFO. Continues from
  // posedge 48, so posedge 57 is the next load edge that pops.
  task automatic test_back_to_back();
    logic [7:0] slots [6];
    logic [7:0] feed [4];
    logic [7:0] expByte;
    logic [3:0] obs;
    logic [3:0] exp;
    int         idx;
    slots = '{8'hFF, 8'h00, 8'h3C, 8'h81, 8'h55, 8'hBC};
    feed  = '{8'hFF, 8'h00, 8'h3C, 8'h81};
    step();
    obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done};
    checks++;
    if (obs !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL b2b_idle_p49: got %b expected 1111", obs);
    end
    bus.valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = feed[i];
      step();
    end
    checks++;
    if (bus.ready_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_full_p53: ready got %b expected 0", bus.ready_out);
    end
    bus.data_in = 8'h55;
    repeat (3) step();
    checks++;
    if (bus.ready_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_full_p56: ready got %b expected 0", bus.ready_out);
    end
    step();
    obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.ready_out};
    checks++;
    if (obs !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL b2b_pop_p57: got %b expected 1101", obs);
    end
    step();
    checks++;
    if (bus.ready_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_refill_p58: ready got %b expected 0", bus.ready_out);
    end
    bus.valid_in = 1'b0;
    for (int p = 59; p <= 104; p++) begin
      step();
      idx     = p - 57;
      expByte = slots[idx / 8];
      exp = {expByte[7 - (idx % 8)], (idx % 8) == 0, (idx / 8) == 5, 1'b1};
      obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_stream p=%0d: got %b expected %b", p, obs, exp);
      end
    end
  endtask

  // T4: three empty slots in RUN are filled with commas (posedges 105..128).
  task automatic test_run_idle();
    logic [7:0] expByte;
    logic [3:0] obs;
    logic [3:0] exp;
    int         idx;
    expByte = 8'hBC;
    for (int p = 105; p <= 128; p++) begin
      step();
      idx = p - 105;
      exp = {expByte[7 - (idx % 8)], (idx % 8) == 0, 1'b1, 1'b1};
      obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL run_idle p=%0d: got %b expected %b", p, obs, exp);
      end
    end
  endtask

  // T5: 0F pushed on load edge 129 into an empty FIFO goes out one slot late.
  task automatic test_no_bypass();
    logic [7:0] slots [2];
    logic [7:0] expByte;
    logic [3:0] obs;
    logic [3:0] exp;
    int         idx;
    slots = '{8'hBC, 8'h0F};
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h0F;
    for (int p = 129; p <= 144; p++) begin
      step();
      bus.valid_in = 1'b0;
      idx     = p - 129;
      expByte = slots[idx / 8];
      exp = {expByte[7 - (idx % 8)], (idx % 8) == 0, (idx / 8) == 0, 1'b1};
      obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL no_bypass p=%0d: got %b expected %b", p, obs, exp);
      end
    end
  endtask

  // T6: C3 launched at posedge 153 with 11 and 22 queued; reset hits while
  // bit 3 is on the line. Afterwards only commas may appear.
  task automatic test_reset_mid_byte();
    logic [7:0] feed [3];
    logic [7:0] expByte;
    logic [4:0] obsR;
    logic [3:0] obs;
    logic [3:0] exp;
    int         idx;
    feed = '{8'hC3, 8'h11, 8'h22};
    step();
    bus.valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = feed[i];
      step();
    end
    bus.valid_in = 1'b0;
    repeat (4) step();
    expByte = 8'hC3;
    for (int p = 153; p <= 157; p++) begin
      step();
      exp = {expByte[7 - (p - 153)], p == 153, 1'b0, 1'b1};
      obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL c3_bits p=%0d: got %b expected %b", p, obs, exp);
      end
    end
    reset = 1'b0;
    #1;
    obsR = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done, bus.ready_out};
    checks++;
    if (obsR !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected 00000", obsR);
    end
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;
    expByte = 8'hBC;
    for (int p = 1; p <= 40; p++) begin
      step();
      idx = p - 1;
      exp = {expByte[7 - (idx % 8)], (idx % 8) == 0, 1'b1, p >= 25};
      obs = {bus.data_out, bus.byte_strobe, bus.comma_out, bus.sync_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL after_reset p=%0d: got %b expected %b", p, obs, exp);
      end
    end
  endtask

  // Scenarios run in sequence; each continues from where the last left off.
  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    test_reset();
    test_sync_idle();
    test_push_in_sync();
    test_back_to_back();
    test_run_idle();
    test_no_bypass();
    test_reset_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
